// File: rtl/uart_frame_host_if.sv
// Bundles the UART CPU-bus pins with the payload and response byte streams.
// The master modport is the frame host side; slave is the UART core plus downstream logic.
interface uart_frame_host_if;
    logic       uart_csn;
    logic       uart_oen;
    logic       uart_wen;
    logic [7:0] uart_data_in;
    logic [7:0] uart_data_out;
    logic       uart_rxrdy;
    logic       uart_txrdy;
    logic       uart_parity_err;
    logic       uart_framing_err;
    logic       uart_overflow;

    logic [7:0] rx_tdata;
    logic       rx_tvalid;
    logic       rx_tready;
    logic       rx_tlast;
    logic [7:0] rx_cmd;
    logic [7:0] rx_len;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    logic [7:0] tx_tdata;
    logic       tx_tvalid;
    logic       tx_tready;

    modport master (
        output uart_csn, uart_oen, uart_wen, uart_data_in,
        input  uart_data_out, uart_rxrdy, uart_txrdy,
        input  uart_parity_err, uart_framing_err, uart_overflow,
        output rx_tdata, rx_tvalid, rx_tlast, rx_cmd, rx_len,
        input  rx_tready,
        output frame_ok, frame_err, err_code,
        input  tx_tdata, tx_tvalid,
        output tx_tready
    );

    modport slave (
        input  uart_csn, uart_oen, uart_wen, uart_data_in,
        output uart_data_out, uart_rxrdy, uart_txrdy,
        output uart_parity_err, uart_framing_err, uart_overflow,
        input  rx_tdata, rx_tvalid, rx_tlast, rx_cmd, rx_len,
        output rx_tready,
        input  frame_ok, frame_err, err_code,
        output tx_tdata, tx_tvalid,
        input  tx_tready
    );
endinterface

// File: rtl/uart_frame_host.sv
// Fabric-side host for the UART CPU bus: reads framed commands (sync/cmd/len/payload/sum)
// out to a payload stream and writes response stream bytes back into the UART.
module uart_frame_host #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TO_W           = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    uart_frame_host_if.master bus
);

    typedef enum logic [2:0] {B_IDLE, B_RD, B_RDWAIT, B_WR, B_WRWAIT} bus_state_t;
    typedef enum logic [2:0] {P_SYNC, P_CMD, P_LEN, P_DATA, P_SUM} parse_state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    bus_state_t   bstate_q, bstate_d;
    parse_state_t pstate_q, pstate_d;

    logic            csn_q, csn_d;
    logic            oen_q, oen_d;
    logic            wen_q, wen_d;
    logic [7:0]      data_in_q, data_in_d;
    logic            tx_tready_q, tx_tready_d;

    logic [7:0]      sum_q, sum_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      rx_tdata_q, rx_tdata_d;
    logic            rx_tvalid_q, rx_tvalid_d;
    logic            rx_tlast_q, rx_tlast_d;
    logic [7:0]      rx_cmd_q, rx_cmd_d;
    logic [7:0]      rx_len_q, rx_len_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            ovf_q;

    logic       sample;
    logic       byte_bad;
    logic       ovf_rise;
    logic       to_count;
    logic [7:0] rd_byte;

    // The B_RD cycle is the one with OEN low, so DATA_OUT and the error flags are taken at its end.
    assign sample   = (bstate_q == B_RD);
    assign rd_byte  = bus.uart_data_out;
    assign byte_bad = bus.uart_parity_err | bus.uart_framing_err;
    assign ovf_rise = bus.uart_overflow & ~ovf_q;
    assign to_count = (pstate_q != P_SYNC) && (bstate_q == B_IDLE) &&
                      !bus.uart_rxrdy && !rx_tvalid_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bstate_q    <= B_IDLE;
            pstate_q    <= P_SYNC;
            csn_q       <= 1'b1;
            oen_q       <= 1'b1;
            wen_q       <= 1'b1;
            data_in_q   <= '0;
            tx_tready_q <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
            rx_tdata_q  <= '0;
            rx_tvalid_q <= 1'b0;
            rx_tlast_q  <= 1'b0;
            rx_cmd_q    <= '0;
            rx_len_q    <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            to_cnt_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            bstate_q    <= bstate_d;
            pstate_q    <= pstate_d;
            csn_q       <= csn_d;
            oen_q       <= oen_d;
            wen_q       <= wen_d;
            data_in_q   <= data_in_d;
            tx_tready_q <= tx_tready_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            rx_tdata_q  <= rx_tdata_d;
            rx_tvalid_q <= rx_tvalid_d;
            rx_tlast_q  <= rx_tlast_d;
            rx_cmd_q    <= rx_cmd_d;
            rx_len_q    <= rx_len_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            to_cnt_q    <= to_cnt_d;
            ovf_q       <= bus.uart_overflow;
        end
    end

    // Strobes are decoded from the next state so they are registered yet line up with it.
    always_comb begin
        bstate_d    = bstate_q;
        csn_d       = 1'b1;
        oen_d       = 1'b1;
        wen_d       = 1'b1;
        data_in_d   = data_in_q;
        tx_tready_d = 1'b0;
        unique case (bstate_q)
            B_IDLE: begin
                if (bus.uart_rxrdy && !rx_tvalid_q) begin
                    bstate_d = B_RD;
                    csn_d    = 1'b0;
                    oen_d    = 1'b0;
                end else if (bus.tx_tvalid && bus.uart_txrdy) begin
                    bstate_d    = B_WR;
                    csn_d       = 1'b0;
                    wen_d       = 1'b0;
                    data_in_d   = bus.tx_tdata;
                    tx_tready_d = 1'b1;
                end
            end
            B_RD:     bstate_d = B_RDWAIT;
            B_RDWAIT: if (!bus.uart_rxrdy) bstate_d = B_IDLE;
            B_WR:     bstate_d = B_WRWAIT;
            B_WRWAIT: if (!bus.uart_txrdy) bstate_d = B_IDLE;
            default:  bstate_d = B_IDLE;
        endcase
    end

    always_comb begin
        pstate_d    = pstate_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        rx_tdata_d  = rx_tdata_q;
        rx_tvalid_d = rx_tvalid_q;
        rx_tlast_d  = rx_tlast_q;
        rx_cmd_d    = rx_cmd_q;
        rx_len_d    = rx_len_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        to_cnt_d    = to_cnt_q;

        if (rx_tvalid_q && bus.rx_tready) begin
            rx_tvalid_d = 1'b0;
            rx_tlast_d  = 1'b0;
        end

        if (sample) begin
            to_cnt_d = '0;
        end else if (to_count) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (sample) begin
            if (byte_bad) begin
                if (pstate_q != P_SYNC) begin
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd1;
                    pstate_d    = P_SYNC;
                end
            end else begin
                unique case (pstate_q)
                    P_SYNC: if (rd_byte == SYNC_BYTE) pstate_d = P_CMD;
                    P_CMD: begin
                        rx_cmd_d = rd_byte;
                        sum_d    = rd_byte;
                        pstate_d = P_LEN;
                    end
                    P_LEN: begin
                        rx_len_d = rd_byte;
                        sum_d    = sum_q + rd_byte;
                        cnt_d    = rd_byte;
                        pstate_d = (rd_byte == 8'd0) ? P_SUM : P_DATA;
                    end
                    P_DATA: begin
                        rx_tdata_d  = rd_byte;
                        rx_tvalid_d = 1'b1;
                        rx_tlast_d  = (cnt_q == 8'd1);
                        sum_d       = sum_q + rd_byte;
                        cnt_d       = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) pstate_d = P_SUM;
                    end
                    P_SUM: begin
                        if (rd_byte == sum_q) begin
                            frame_ok_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'd0;
                        end
                        pstate_d = P_SYNC;
                    end
                    default: pstate_d = P_SYNC;
                endcase
            end
        end else if (to_count && (to_cnt_q == TO_LAST)) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd2;
            pstate_d    = P_SYNC;
        end

        // Overflow is evaluated last so it overrides any byte result from the same cycle.
        if (ovf_rise && (pstate_q != P_SYNC)) begin
            frame_ok_d  = 1'b0;
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            pstate_d    = P_SYNC;
        end

        if (pstate_d == P_SYNC) to_cnt_d = '0;
    end

    assign bus.uart_csn     = csn_q;
    assign bus.uart_oen     = oen_q;
    assign bus.uart_wen     = wen_q;
    assign bus.uart_data_in = data_in_q;
    assign bus.tx_tready    = tx_tready_q;
    assign bus.rx_tdata     = rx_tdata_q;
    assign bus.rx_tvalid    = rx_tvalid_q;
    assign bus.rx_tlast     = rx_tlast_q;
    assign bus.rx_cmd       = rx_cmd_q;
    assign bus.rx_len       = rx_len_q;
    assign bus.frame_ok     = frame_ok_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.err_code     = err_code_q;

endmodule
